// File: rtl/core_boot_ctrl.sv
// Boot and run sequencer: streams instruction words into byte-wide memory,
// releases the core, then times the run until ECALL or a cycle limit.
module core_boot_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INSN = 32'h00000073
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              core_rst_n,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_insn,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [CNT_W-1:0]  cycles,
    output logic [ADDR_W-2:0] words
);

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WR,
        RELEASE,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_W-2:0] FULL_WORDS = {1'b1, {(ADDR_W-2){1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W-2:0] words_q, words_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [7:0]        im_wdata_q, im_wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              full;
    logic              halt_hit;
    logic              limit_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            words_q      <= '0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            last_q       <= last_d;
            words_q      <= words_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    assign full      = (words_q == FULL_WORDS);
    assign halt_hit  = fetch_valid && (fetch_insn == HALT_INSN);
    assign limit_hit = (cycle_limit != '0) && ((cycles_q + CNT_W'(1)) == cycle_limit);

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        data_d    = data_q;
        last_d    = last_q;
        words_d   = words_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        ld_ready  = (state_q == LD_IDLE) && !full;

        case (state_q)
            LD_IDLE: begin
                if (ld_valid) begin
                    if (full) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        data_d  = ld_data;
                        last_d  = ld_last;
                        idx_d   = 2'd0;
                        state_d = LD_WR;
                    end
                end
            end
            LD_WR: begin
                if (idx_q == 2'd3) begin
                    ptr_d   = ptr_q + ADDR_W'(4);
                    words_d = words_q + 1'b1;
                    state_d = last_q ? RELEASE : LD_IDLE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            RELEASE: state_d = RUN;
            RUN: begin
                cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
                if (halt_hit) begin
                    state_d = DONE;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = DONE;
        endcase

        im_we_d      = (state_d == LD_WR);
        im_addr_d    = im_we_d ? ptr_d + ADDR_W'(idx_d) : '0;
        im_wdata_d   = im_we_d ? data_d[{idx_d, 3'b000} +: 8] : 8'h00;
        core_rst_n_d = (state_d == RUN);
        running_d    = (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign err        = err_q;
    assign cycles     = cycles_q;
    assign words      = words_q;

endmodule

// File: doc/core_boot_ctrl.md
# core_boot_ctrl

Boot and run controller for the RV32 datapath simulation and FPGA harness. It accepts a stream of 32-bit instruction words and writes them little-endian, one byte per cycle, into the byte-wide instruction memory. It holds the core in reset during the load, releases it, then counts cycles until an ECALL fetch or a programmable cycle limit ends the run. It replaces the hand-written byte-poke initial blocks and free-running clock stimulus with a reusable, parametrised sequencer.

## Interface
Parameters:
- ADDR_W, 12, instruction memory byte-address width (2^ADDR_W bytes)
- CNT_W, 32, cycle counter and limit width
- HALT_INSN, 32'h00000073, instruction word that ends the run (ECALL)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  load word valid
- ld_ready  out  1  controller can accept a word
- ld_data  in  32  instruction word
- ld_last  in  1  marks the final word of the program
- im_we  out  1  instruction memory byte write enable
- im_addr  out  ADDR_W  byte address
- im_wdata  out  8  byte data
- core_rst_n  out  1  active-low reset to the datapath
- fetch_valid  in  1  core fetched an instruction this cycle
- fetch_insn  in  32  fetched instruction word
- cycle_limit  in  CNT_W  run limit; 0 means unlimited
- running  out  1  core released and executing
- done  out  1  run finished (sticky until reset)
- timeout  out  1  run ended by cycle limit
- err  out  1  load overflow
- cycles  out  CNT_W  cycles elapsed since release
- words  out  ADDR_W-1  words loaded

## Operation
- Reset values: all outputs 0, except ld_ready=1 and core_rst_n=0. Write pointer is 0 and state is LD_IDLE.
- States: LD_IDLE, LD_WR, RELEASE, RUN, DONE.
- LD_IDLE:
  - ld_ready=1.
  - On ld_valid&&ld_ready: latch ld_data and ld_last, then go to LD_WR with byte index 0.
- LD_WR:
  - ld_ready=0, im_we=1 for exactly 4 cycles.
  - Byte k=0..3: im_addr=ptr+k, im_wdata=data[8k+7:8k] (LSB first).
  - After byte 3: ptr+=4 and words+=1. Go to RELEASE if last, else LD_IDLE.
- Full: when words==2^(ADDR_W-2), ld_ready=0. If ld_valid is then asserted in LD_IDLE: err=1, go to DONE, and the core is never released.
- RELEASE: one cycle with core_rst_n=0 and im_we=0, then RUN.
- RUN:
  - core_rst_n=1, running=1, cycles increments by 1 every clock.
  - Halt: fetch_valid && fetch_insn==HALT_INSN → DONE.
  - Limit: cycle_limit!=0 && cycles+1==cycle_limit → DONE with timeout=1.
  - Halt and limit in the same cycle: halt wins, timeout=0.
- cycles saturates at all-ones and does not wrap.
- DONE:
  - running=0 and done=1.
  - core_rst_n is driven to 0 to freeze the core. cycles and words hold their values.
  - ld_ready=0 and ld_valid is ignored. Only rst_n leaves DONE.
- ld_valid outside LD_IDLE is ignored; the source must hold the word until ld_ready.

## Timing
- Acceptance to the first byte write: 1 cycle. One word occupies 5 cycles (1 accept + 4 writes). Throughput is 1 word per 5 cycles.
- Last byte write to core_rst_n rising: 2 cycles (RELEASE, then RUN registered).
- cycles reads 1 at the end of the first RUN cycle.
- Halt or limit is detected in cycle N. done=1 and core_rst_n=0 from cycle N+1. cycles holds the count including cycle N.
- All outputs are registered; there is no combinational path from inputs to outputs except ld_ready, which is a function of state and words only.
- rst_n asserted at any point, mid-word included, returns the block immediately to reset values. No partial word completes.

## Test plan
- Load 7 words, the last with ld_last: 0x00500613, 0x00B06693, 0x00C68733, 0x40C687B3, 0x01070813, 0x00D868B3, 0x00D80933.
  - → 28 byte writes; addr 0..3 carry 0x13, 0x06, 0x50, 0x00.
  - → words=7; core_rst_n rises 2 cycles after the byte at addr 27.
- Core fetches 0x00000073 at RUN cycle 40 with cycle_limit=0 → done=1, timeout=0, cycles=40, core_rst_n=0 next cycle.
- cycle_limit=100 with no halt → done=1, timeout=1, cycles=100.
- cycle_limit=10 and HALT_INSN fetched in RUN cycle 10 → timeout=0, done=1, cycles=10.
- ADDR_W=4 (4 words): stream 5 words with ld_valid held → ld_ready=0 after word 4, then err=1 and done=1; core_rst_n stays 0.
- rst_n pulsed low during byte 2 of word 3 → all outputs at reset values immediately. After release, reloading from addr 0 works.
